spi_master: RTL and testbench

SPI mode-0 master (CPOL=0, CPHA=0), MSB first. Generates sclk/cs_n/mosi for our spi_slave and captures miso.
- Sits between an on-chip controller (start/done handshake) and the external SPI pins.
- One WIDTH-bit full-duplex transfer per start; cs_n stays low for exactly one word.

---
 rtl/spi_master.sv | 119 +++++++++++
 tb/tb_spi_master.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master (CPOL=0, CPHA=0), MSB first, one WIDTH-bit full-duplex word per start.
// Define SPI_MASTER_MISO_SYNC_EN to pass miso through a 2-flop synchronizer (requires CLK_DIV >= 3).
module spi_master #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             sclk,
    output logic             cs_n,
    output logic             mosi,
    input  logic             miso
);
    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
    logic             sclk_q, sclk_d, cs_n_q, cs_n_d, done_q, done_d;
    logic             last, sample, miso_s;

    assign last = cnt_q == CNT_LAST;
`ifdef SPI_MASTER_MISO_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], miso};
    end
    // two clocks after the rising sclk edge, sync_q[1] holds miso as it was on that edge
    assign miso_s = sync_q[1];
    assign sample = state_q == HIGH && cnt_q == CW'(1);
`else
    assign miso_s = miso;
    assign sample = (state_q == SETUP || state_q == LOW) && last;
`endif

    // the tx register shifts in zeros, so mosi falls to 0 after the last bit
    assign mosi    = tx_q[WIDTH-1];
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign done    = done_q;
    assign busy    = state_q != IDLE;
    assign rx_data = rx_data_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = (state_q == IDLE || last) ? '0 : cnt_q + CW'(1);
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = sample ? {rx_q[WIDTH-2:0], miso_s} : rx_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                tx_d    = tx_data;
                cs_n_d  = 1'b0;
                state_d = SETUP;
            end
            SETUP: if (last) begin
                sclk_d  = 1'b1;
                state_d = HIGH;
            end
            HIGH: if (last) begin
                sclk_d  = 1'b0;
                tx_d    = {tx_q[WIDTH-2:0], 1'b0};
                state_d = bit_q == BIT_LAST ? HOLD : LOW;
            end
            LOW: if (last) begin
                sclk_d  = 1'b1;
                bit_d   = bit_q + BW'(1);
                state_d = HIGH;
            end
            HOLD: if (last) begin
                cs_n_d    = 1'b1;
                rx_data_d = rx_q;
                done_d    = 1'b1;
                bit_d     = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized scoreboard bench for spi_master with a mode-0 slave model and optional mosi->miso loopback.
module tb_spi_master;
    localparam int W = 8;
`ifdef SPI_MASTER_MISO_SYNC_EN
    localparam int D = 3;
`else
    localparam int D = 4;
`endif
    localparam int TOT = (2 * W + 1) * D;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, miso;
    logic [W-1:0] tx_data = '0, rx_data;
    logic         busy, done, sclk, cs_n, mosi;

    spi_master #(.WIDTH(W), .CLK_DIV(D)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .busy(busy), .done(done),
        .rx_data(rx_data), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    // mode-0 slave: presents MSB on cs_n fall, shifts on sclk fall, captures mosi on sclk rise
    logic [W-1:0] slave_word = '0, s_sh = '0, s_rx = '0;
    bit           loop = 1'b0;
    assign miso = loop ? mosi : s_sh[W-1];
    always @(negedge cs_n) begin
        s_sh = slave_word;
        s_rx = '0;
    end
    always @(negedge sclk) if (!cs_n) s_sh = s_sh << 1;
    always @(posedge sclk) if (!cs_n) s_rx = {s_rx[W-2:0], mosi};

    typedef struct {
        logic [W-1:0] rx;
        logic [W-1:0] tx;
    } exp_t;
    exp_t  sb[$];
    int    tests = 0, fails = 0;
    int    bad[6] = '{default: 0};
    string names[6] = '{"busy", "cs_n", "sclk", "mosi", "done", "rx_hold"};

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void check_windows();
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (bad[i] != 0) begin
                fails++;
                $display("FAIL %s_timing: %0d mismatching cycles, expected 0", names[i], bad[i]);
            end
            bad[i] = 0;
        end
    endfunction

    // monitor: timing model derived from the cycle offset t since the accepting edge
    int           cyc = 0, e0 = 0, t = 0, j = 0;
    bit           m_busy = 1'b0, st, rs, exp_done;
    logic [W-1:0] m_tx = '0, m_rx = '0, txs;
    logic         e_sclk, e_mosi;
    exp_t         e;
    initial begin
        forever begin
            @(posedge clk);
            st = start;
            rs = rst;
            txs = tx_data;
            cyc++;
            #1;
            exp_done = 1'b0;
            if (rs) begin
                m_busy = 1'b0;
                m_rx   = '0;
                check("rst_busy", W'(busy), '0);
                check("rst_done", W'(done), '0);
                check("rst_cs_n", W'(cs_n), W'(1));
                check("rst_sclk", W'(sclk), '0);
                check("rst_mosi", W'(mosi), '0);
                check("rst_rx_data", rx_data, '0);
            end else begin
                if (m_busy) begin
                    if (cyc - e0 == TOT) begin
                        m_busy   = 1'b0;
                        exp_done = 1'b1;
                    end
                end else if (st) begin
                    m_busy = 1'b1;
                    e0     = cyc;
                    m_tx   = txs;
                end
                t = cyc - e0;
                j = t / (2 * D);
                e_sclk = m_busy && t >= D && (t / D) % 2 == 1;
                e_mosi = (m_busy && j < W) ? m_tx[W-1-j] : 1'b0;
                if (busy !== m_busy) bad[0]++;
                if (cs_n !== !m_busy) bad[1]++;
                if (sclk !== e_sclk) bad[2]++;
                if (mosi !== e_mosi) bad[3]++;
                if (done !== exp_done) bad[4]++;
                if (exp_done) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL scoreboard: done with no expected transfer queued");
                    end else begin
                        e = sb.pop_front();
                        check("rx_data", rx_data, e.rx);
                        check("slave_rx", s_rx, e.tx);
                        m_rx = e.rx;
                    end
                    check_windows();
                end else if (rx_data !== m_rx) bad[5]++;
            end
        end
    end

    task automatic wait_accept();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 5);
        if (!busy) begin
            tests++;
            fails++;
            $display("FAIL accept: busy=%b after %0d cycles, expected 1", busy, n);
        end
    endtask

    task automatic xfer(input logic [W-1:0] tx, input logic [W-1:0] sw, input bit lp, input bit hold);
        int n = 0;
        sb.push_back('{rx: (lp ? tx : sw), tx: tx});
        slave_word = sw;
        loop       = lp;
        tx_data    = tx;
        start      = 1'b1;
        wait_accept();
        forever begin
            @(negedge clk);
            n++;
            if (!busy || n > TOT + 5) break;
            start   = hold ? 1'b1 : 1'($urandom_range(0, 1));
            tx_data = W'($urandom);
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: busy=%b after %0d cycles, expected 0", busy, n);
        end
        start = hold;
    endtask

    task automatic abort_xfer(input logic [W-1:0] tx, input logic [W-1:0] sw);
        slave_word = sw;
        loop       = 1'b0;
        tx_data    = tx;
        start      = 1'b1;
        wait_accept();
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        xfer(8'hA5, 8'h3C, 1'b0, 1'b0);
        xfer(8'h81, 8'h00, 1'b1, 1'b0);
        xfer(8'h00, 8'hFF, 1'b1, 1'b0);
        xfer(8'hFF, 8'h12, 1'b0, 1'b1);
        xfer(8'h01, 8'h34, 1'b0, 1'b0);
        abort_xfer(8'h77, 8'hE7);
        xfer(8'h5A, 8'hC3, 1'b0, 1'b0);
        xfer(8'hC3, 8'h96, 1'b1, 1'b0);
        xfer(8'h69, 8'h96, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            xfer(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), i < 23 && $urandom_range(0, 2) == 0);
            if (!start) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check_windows();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1ms, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
